// File: rtl/mult_div_unit.sv
// Iterative-latency multiply/divide unit holding the HI/LO register pair.
// Results are computed from operands latched at Start and committed on the completion edge.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        HLWrite,
    input  logic        HLSel,
    output logic        Busy,
    output logic [31:0] HLOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, stateNext;
    logic [3:0]  count, countNext;
    logic [31:0] opA, opB;
    logic [2:0]  opCode;
    logic        done;

    logic        mulSigned, divSigned;
    logic [63:0] extA, extB, product, divResult, result;
    logic [31:0] magA, magB, uQuot, uRem, quot, rem;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stateNext = state;
        countNext = count;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (MDOp[2:1] == 2'b01) begin
                        stateNext = DIV;
                        countNext = 4'd9;
                    end else begin
                        stateNext = MUL;
                        countNext = 4'd4;
                    end
                end
            end
            MUL, DIV: begin
                if (count == 4'd0) begin
                    stateNext = IDLE;
                    done      = 1'b1;
                end else begin
                    countNext = count - 4'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Signed division works on magnitudes, so 0x80000000 / -1 needs no special case.
    always_comb begin
        mulSigned = ~opCode[0];
        divSigned = (opCode == 3'b010);
        extA      = {{32{mulSigned & opA[31]}}, opA};
        extB      = {{32{mulSigned & opB[31]}}, opB};
        product   = extA * extB;

        magA  = (divSigned && opA[31]) ? (~opA + 32'd1) : opA;
        magB  = (divSigned && opB[31]) ? (~opB + 32'd1) : opB;
        uQuot = magA / magB;
        uRem  = magA % magB;
        quot  = (divSigned && (opA[31] ^ opB[31])) ? (~uQuot + 32'd1) : uQuot;
        rem   = (divSigned && opA[31]) ? (~uRem + 32'd1) : uRem;
        divResult = (magB == 32'd0) ? {opA, 32'hFFFF_FFFF} : {rem, quot};

        case (opCode[2:1])
            2'b00:   result = product;
            2'b01:   result = divResult;
            2'b10:   result = {HI, LO} + product;
            default: result = {HI, LO} - product;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= 4'd0;
            opA    <= 32'd0;
            opB    <= 32'd0;
            opCode <= 3'd0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (state == IDLE && Start) begin
                opA    <= D1;
                opB    <= D2;
                opCode <= MDOp;
            end
        end
    end

    // A Start in IDLE always wins over a simultaneous mthi/mtlo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (done) begin
            {HI, LO} <= result;
        end else if (state == IDLE && HLWrite && !Start) begin
            if (HLSel) HI <= D1;
            else       LO <= D1;
        end
    end

    assign Busy  = (state != IDLE);
    assign HLOut = HLSel ? HI : LO;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mult_div_unit;

    logic        clk, reset, Start, HLWrite, HLSel;
    logic [2:0]  MDOp;
    logic [31:0] D1, D2;
    logic        Busy;
    logic [31:0] HLOut, HI, LO;

    int nTests = 0;
    int nFails = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .D1(D1), .D2(D2),
        .HLWrite(HLWrite), .HLSel(HLSel), .Busy(Busy), .HLOut(HLOut), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-operation arithmetic, committed after the documented latency.
    function automatic logic [63:0] modelResult(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
        longint      sp;
        logic [63:0] up;
        int          q, r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: return sp;
            3'd1: return up;
            3'd4: return acc + sp;
            3'd5: return acc + up;
            3'd6: return acc - sp;
            3'd7: return acc - up;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    logic [31:0] mHi = 0, mLo = 0, mA = 0, mB = 0;
    logic [2:0]  mOp = 0;
    int          mLeft = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mHi <= 0; mLo <= 0; mA <= 0; mB <= 0; mOp <= 0; mLeft <= 0;
        end else if (mLeft > 0) begin
            mLeft <= mLeft - 1;
            if (mLeft == 1) {mHi, mLo} <= modelResult(mOp, mA, mB, {mHi, mLo});
        end else if (Start) begin
            mA <= D1; mB <= D2; mOp <= MDOp;
            mLeft <= (MDOp == 3'd2 || MDOp == 3'd3) ? 10 : 5;
        end else if (HLWrite) begin
            if (HLSel) mHi <= D1;
            else       mLo <= D1;
        end
    end

    always @(negedge clk) begin
        check("model Busy", {31'd0, Busy}, {31'd0, mLeft > 0});
        check("model HI", HI, mHi);
        check("model LO", LO, mLo);
        check("model HLOut", HLOut, HLSel ? mHi : mLo);
    end

    task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hw, input logic hs);
        Start = st; MDOp = op; D1 = a; D2 = b; HLWrite = hw; HLSel = hs;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat);
        drive(1'b1, op, a, b, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 5)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("reset Busy", {31'd0, Busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        check("reset HLOut", HLOut, 32'd0);
        tick(2);
        reset = 1'b1;

        // mult -1*2 with Busy tracked cycle by cycle
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("mult busy start", {31'd0, Busy}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("mult busy", {31'd0, Busy}, 32'd1);
        end
        tick(1);
        check("mult done busy", {31'd0, Busy}, 32'd0);
        check("mult HI", HI, 32'hFFFF_FFFF);
        check("mult LO", LO, 32'hFFFF_FFFE);

        runOp(3'd1, 32'hFFFF_FFFF, 32'd2, 5);
        check("multu HI", HI, 32'h0000_0001);
        check("multu LO", LO, 32'hFFFF_FFFE);

        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 9);
        check("div early busy", {31'd0, Busy}, 32'd1);
        tick(1);
        check("div LO", LO, 32'hFFFF_FFFD);
        check("div HI", HI, 32'hFFFF_FFFF);

        runOp(3'd3, 32'd7, 32'd0, 10);
        check("divu0 LO", LO, 32'hFFFF_FFFF);
        check("divu0 HI", HI, 32'd7);

        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("divovf LO", LO, 32'h8000_0000);
        check("divovf HI", HI, 32'd0);

        runOp(3'd2, 32'hFFFF_FFFB, 32'd0, 10);
        check("div0 LO", LO, 32'hFFFF_FFFF);
        check("div0 HI", HI, 32'hFFFF_FFFB);

        // accumulate via mthi/mtlo, maddu, msub
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        tick(1);
        drive(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        tick(1);
        check("mtlo HLOut", HLOut, 32'hFFFF_FFFF);
        runOp(3'd5, 32'd1, 32'd1, 5);
        check("maddu HI", HI, 32'd1);
        check("maddu LO", LO, 32'd0);
        runOp(3'd6, 32'd1, 32'd1, 5);
        check("msub HI", HI, 32'd0);
        check("msub LO", LO, 32'hFFFF_FFFF);

        // collision: second Start and HLWrite while a div is in flight
        drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(1);
        drive(1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 3'd0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        tick(1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("busy HLWrite LO", LO, 32'hFFFF_FFFF);
        tick(7);
        check("coll busy", {31'd0, Busy}, 32'd0);
        check("coll LO", LO, 32'd14);
        check("coll HI", HI, 32'd2);
        tick(1);
        check("coll no restart", {31'd0, Busy}, 32'd0);

        // reset abort mid-div, then Start on the first edge after release
        drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(3);
        reset = 1'b0;
        #1;
        check("abort Busy", {31'd0, Busy}, 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        tick(2);
        reset = 1'b1;
        runOp(3'd0, 32'd6, 32'd7, 5);
        check("post-reset LO", LO, 32'd42);
        check("post-reset HI", HI, 32'd0);

        // Start beats simultaneous HLWrite
        drive(1'b1, 3'd0, 32'd5, 32'd3, 1'b1, 1'b1);
        tick(1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("start prio HI", HI, 32'd0);
        tick(5);
        check("start prio LO", LO, 32'd15);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 4) == 0, 3'($urandom % 8), pick(), pick(),
                  ($urandom % 5) == 0, 1'($urandom % 2));
            tick(1);
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int budget = 0; budget < 20 && Busy; budget++) tick(1);
        check("drain idle", {31'd0, Busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port Start, input, 1, one-cycle pulse launching an operation in the EX stage.
REQ-004 SHALL have port MDOp, input, 3, operation code: 000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
REQ-005 SHALL have port D1, input, 32, forwarded rs operand.
REQ-006 SHALL have port D2, input, 32, forwarded rt operand.
REQ-007 SHALL have port HLWrite, input, 1, mthi/mtlo write strobe.
REQ-008 SHALL have port HLSel, input, 1, 1 = HI and 0 = LO, used for both HLWrite and HLOut.
REQ-009 SHALL have port Busy, output, 1, operation in progress; consumed by the hazard unit stall logic.
REQ-010 SHALL have port HLOut, output, 32, HI when HLSel=1, else LO (mfhi/mflo data).
REQ-011 SHALL have ports HI and LO, output, 32 each, architectural register values.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV.
- IDLE -> MUL on Start with MDOp in {mult, multu, madd, maddu, msub, msubu}.
- IDLE -> DIV on Start with MDOp in {div, divu}.
REQ-013 SHALL latch D1, D2 and MDOp on the Start edge; the operands SHALL not be sampled again.
REQ-014 SHALL use a 4-bit down-counter loaded with 4 on entry to MUL and 9 on entry to DIV; it SHALL decrement each cycle.
REQ-015 SHALL return to IDLE and write HI/LO on the edge where the counter equals 0.
- mult/madd/msub: total latency 5 cycles from the Start edge.
- div: total latency 10 cycles from the Start edge.
REQ-016 SHALL hold Busy=1 in MUL and DIV and Busy=0 in IDLE; Busy is registered, so it is 0 during the Start cycle itself (the hazard unit covers that cycle using its EX-stage decode).
REQ-017 mult/multu SHALL form the 64-bit signed/unsigned product, with {HI,LO} = product.
REQ-018 madd/maddu SHALL set {HI,LO} = {HI,LO} + product, and msub/msubu SHALL set {HI,LO} = {HI,LO} - product.
- Arithmetic is modulo 2^64.
- The {HI,LO} value used is the one present at completion.
REQ-019 div SHALL set LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend; divu SHALL do the same unsigned.
REQ-020 Divide by zero SHALL set LO=0xFFFFFFFF and HI=D1, with normal latency.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL set LO=0x80000000 and HI=0.
REQ-022 Start while Busy=1 SHALL be ignored, and the in-flight operation SHALL continue unaffected.
REQ-023 HLWrite while Busy=0 SHALL write D1 into HI (HLSel=1) or LO (HLSel=0) on the next edge; HLWrite while Busy=1 SHALL be ignored.
REQ-024 Simultaneous Start and HLWrite in IDLE SHALL give Start priority; the HLWrite SHALL be dropped.
REQ-025 HLOut SHALL be combinational from the HI/LO registers; during an operation HI/LO SHALL keep their old values until the completion edge.

Reset
REQ-026 Asserting reset=0 SHALL immediately clear the following, independent of clk:
- HI, LO and HLOut to 0.
- Busy to 0.
- State to IDLE.
- Counter to 0.
- Latched operands to 0.
REQ-027 Reset during MUL or DIV SHALL abort the operation without any HI/LO update.
REQ-028 The first Start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- mult: D1=0xFFFFFFFF, D2=2 -> Busy high for cycles 1-4 after Start; at cycle 5, HI=0xFFFFFFFF and LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div: D1=-7 (0xFFFFFFF9), D2=2 -> after 10 cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF; divu 7/0 -> LO=0xFFFFFFFF, HI=7.
- Accumulate: mthi 0, mtlo 0xFFFFFFFF, maddu 1*1 -> HI=1, LO=0; then msub 1*1 -> HI=0, LO=0xFFFFFFFF.
- Collision: a second Start (mult 3*3) at cycle 2 of a div 100/7 -> ignored; LO=14, HI=2 at cycle 10; HLWrite during Busy -> no change.
- Reset abort: reset=0 mid-div (cycle 4) -> Busy=0 and HI=LO=0 immediately; after release, mult 6*7 -> LO=42 at cycle 5.
